// File: rtl/falling_object_mover.sv
//------------------------------------------------------------------------------
// Module      : falling_object_mover
// Description : Position engine for a falling object. Latches the spawn X
//               while loadX_i is high, then advances a fixed-point Y once per
//               video frame by the sanitised speed. Emits a one-cycle
//               exceed_o pulse when the object leaves the bottom of the screen.
// Revision    : 1.0 - initial release
//
// Optional feature macro: FALLING_OBJ_GRAVITY_EN
//   Defined   : an internal velocity grows by GRAVITY each frame (clamped to
//               MAX_SPEED); the input speed acts as a floor on the step.
//   Undefined : constant-speed motion using the sanitised input speed only.
//
// Ports:
//   clk_i          in   1       system clock
//   resetN_i       in   1       asynchronous active-low reset
//   startOfFrame_i in   1       one-cycle pulse per frame (only motion tick)
//   loadX_i        in   1       reload request: latch X, Y back to spawn
//   initialX_i     in   11 (s)  spawn X in pixels
//   visible_i      in   1       object active
//   speed_i        in   32 (s)  fall speed in sub-pixels/frame
//   topLeftX_o     out  11 (s)  current X in pixels
//   topLeftY_o     out  11 (s)  current Y in pixels (integer part, truncated)
//   exceed_o       out  1       one-cycle pulse: object passed BOTTOM_Y
//   falling_o      out  1       high while the object is falling
//------------------------------------------------------------------------------
`default_nettype none

module falling_object_mover #(
    parameter int FP_SHIFT  = 6,
    parameter int INITIAL_Y = -64,
    parameter int BOTTOM_Y  = 480,
    parameter int MAX_SPEED = 2048
`ifdef FALLING_OBJ_GRAVITY_EN
    ,
    parameter int GRAVITY   = 4
`endif
) (
    input  logic               clk_i,
    input  logic               resetN_i,
    input  logic               startOfFrame_i,
    input  logic               loadX_i,
    input  logic signed [10:0] initialX_i,
    input  logic               visible_i,
    input  logic signed [31:0] speed_i,
    output logic signed [10:0] topLeftX_o,
    output logic signed [10:0] topLeftY_o,
    output logic               exceed_o,
    output logic               falling_o
);

    localparam logic signed [31:0] Y_SPAWN = INITIAL_Y * (2 ** FP_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FALLING = 2'd1,
        S_EXITED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [10:0] x_q, x_d;
    logic signed [31:0] y_q, y_d;
    logic               exceed_q, exceed_d;

    logic signed [31:0] eff;
    logic signed [31:0] step;
    logic        [32:0] sum_wide;
    logic signed [31:0] y_step;
    logic               crossed;

    // Negative speeds stall the object; large speeds are clamped.
    always_comb begin
        if (speed_i < 0) begin
            eff = '0;
        end else if (speed_i > MAX_SPEED) begin
            eff = MAX_SPEED;
        end else begin
            eff = speed_i;
        end
    end

`ifdef FALLING_OBJ_GRAVITY_EN
    logic signed [31:0] vel_q, vel_d;
    logic signed [31:0] vel_inc;
    logic signed [31:0] vel_tick;

    // Velocity after this frame's acceleration; the step uses the new value.
    always_comb begin
        vel_inc  = vel_q + GRAVITY;
        vel_tick = (vel_inc > MAX_SPEED) ? MAX_SPEED : vel_inc;
        step     = (vel_tick > eff) ? vel_tick : eff;
    end
`else
    always_comb begin
        step = eff;
    end
`endif

    // step is never negative, so only positive overflow needs saturating.
    always_comb begin
        sum_wide = {y_q[31], y_q} + {step[31], step};
        y_step   = (sum_wide[32:31] == 2'b01) ? 32'sh7FFF_FFFF : sum_wide[31:0];
        crossed  = ((y_step >>> FP_SHIFT) >= BOTTOM_Y);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        exceed_d = 1'b0;
`ifdef FALLING_OBJ_GRAVITY_EN
        vel_d    = vel_q;
`endif
        if (loadX_i) begin
            // Reload wins over every other event, including a tick or a crossing.
            x_d     = initialX_i;
            y_d     = Y_SPAWN;
            state_d = S_IDLE;
`ifdef FALLING_OBJ_GRAVITY_EN
            vel_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (visible_i) begin
                        state_d = S_FALLING;
                    end
                end
                S_FALLING: begin
                    if (startOfFrame_i) begin
                        y_d = y_step;
`ifdef FALLING_OBJ_GRAVITY_EN
                        vel_d = vel_tick;
`endif
                        if (crossed) begin
                            exceed_d = 1'b1;
                            state_d  = S_EXITED;
                        end else if (!visible_i) begin
                            state_d = S_IDLE;
                        end
                    end else if (!visible_i) begin
                        state_d = S_IDLE;
                    end
                end
                S_EXITED: begin
                    state_d = S_EXITED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= Y_SPAWN;
            exceed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            exceed_q <= exceed_d;
        end
    end

`ifdef FALLING_OBJ_GRAVITY_EN
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            vel_q <= '0;
        end else begin
            vel_q <= vel_d;
        end
    end
`endif

    assign topLeftX_o = x_q;
    assign topLeftY_o = 11'(y_q >>> FP_SHIFT);
    assign exceed_o   = exceed_q;
    assign falling_o  = (state_q == S_FALLING);

endmodule

`default_nettype wire

// File: tb/tb_falling_object_mover.sv
//------------------------------------------------------------------------------
// Module      : tb_falling_object_mover
// Description : Scoreboard bench for falling_object_mover. A driver issues one
//               input vector per cycle and pushes the reference model's
//               expected outputs; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_falling_object_mover;

    logic               clk_i = 1'b0;
    logic               resetN_i;
    logic               startOfFrame_i;
    logic               loadX_i;
    logic signed [10:0] initialX_i;
    logic               visible_i;
    logic signed [31:0] speed_i;
    logic signed [10:0] topLeftX_o;
    logic signed [10:0] topLeftY_o;
    logic               exceed_o;
    logic               falling_o;

    always #5 clk_i = ~clk_i;

    falling_object_mover dut (
        .clk_i          (clk_i),
        .resetN_i       (resetN_i),
        .startOfFrame_i (startOfFrame_i),
        .loadX_i        (loadX_i),
        .initialX_i     (initialX_i),
        .visible_i      (visible_i),
        .speed_i        (speed_i),
        .topLeftX_o     (topLeftX_o),
        .topLeftY_o     (topLeftY_o),
        .exceed_o       (exceed_o),
        .falling_o      (falling_o)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        exc;
        logic        fall;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: position in sub-pixels, plus which phase of life the
    // object is in (0 waiting, 1 falling, 2 gone off the bottom).
    longint      m_y;
    logic [10:0] m_x;
    longint      m_vel;
    int          m_phase;
    bit          m_exc;

    function automatic void model_step(bit rst_n, bit ld, logic [10:0] ix,
                                       bit vis, bit sof, int spd);
        longint e;
        longint stp;
        longint ny;
        if (!rst_n) begin
            m_x = '0; m_y = -64 * 64; m_vel = 0; m_phase = 0; m_exc = 0;
            return;
        end
        m_exc = 0;
        if (ld) begin
            m_x = ix; m_y = -64 * 64; m_vel = 0; m_phase = 0;
            return;
        end
        if (m_phase == 0) begin
            if (vis) m_phase = 1;
        end else if (m_phase == 1) begin
            if (sof) begin
                e = (spd < 0) ? 0 : ((spd > 2048) ? 2048 : spd);
                stp = e;
`ifdef FALLING_OBJ_GRAVITY_EN
                m_vel = (m_vel + 4 > 2048) ? 2048 : m_vel + 4;
                stp = (m_vel > e) ? m_vel : e;
`endif
                ny = m_y + stp;
                if (ny > 64'sd2147483647) ny = 64'sd2147483647;
                m_y = ny;
                if ((ny >>> 6) >= 480) begin
                    m_exc = 1; m_phase = 2;
                end else if (!vis) begin
                    m_phase = 0;
                end
            end else if (!vis) begin
                m_phase = 0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t o;
        o.x    = m_x;
        o.y    = 11'(m_y >>> 6);
        o.exc  = m_exc;
        o.fall = (m_phase == 1);
        return o;
    endfunction

    task automatic cycle(input bit rst_n, input bit ld, input logic [10:0] ix,
                         input bit vis, input bit sof, input int spd);
        @(negedge clk_i);
        resetN_i       = rst_n;
        loadX_i        = ld;
        initialX_i     = ix;
        visible_i      = vis;
        startOfFrame_i = sof;
        speed_i        = spd;
        model_step(rst_n, ld, ix, vis, sof, spd);
        exp_q.push_back(model_out());
    endtask

    // Assert reset between edges and confirm outputs clear without waiting
    // for a clock edge.
    task automatic reset_now();
        exp_t e;
        @(negedge clk_i);
        resetN_i = 1'b0;
        model_step(0, 0, '0, 0, 0, 0);
        e = model_out();
        #1;
        checks++;
        if ({topLeftX_o, topLeftY_o, exceed_o, falling_o} !== e) begin
            failures++;
            $display("FAIL async_reset x=%0d y=%0d exc=%0b fall=%0b required x=%0d y=%0d exc=%0b fall=%0b",
                     topLeftX_o, topLeftY_o, exceed_o, falling_o,
                     $signed(e.x), $signed(e.y), e.exc, e.fall);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so one expected entry per clock edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({topLeftX_o, topLeftY_o, exceed_o, falling_o} !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t x=%0d y=%0d exc=%0b fall=%0b required x=%0d y=%0d exc=%0b fall=%0b",
                             $time, topLeftX_o, topLeftY_o, exceed_o, falling_o,
                             $signed(e.x), $signed(e.y), e.exc, e.fall);
                end
            end
        end
    end

    initial begin
        resetN_i = 1'b0; startOfFrame_i = 1'b0; loadX_i = 1'b0;
        initialX_i = '0; visible_i = 1'b0; speed_i = '0;
        model_step(0, 0, '0, 0, 0, 0);

        repeat (2) cycle(0, 0, 11'd0, 0, 0, 0);

        // Spawn at X=304 and start falling.
        repeat (2) cycle(1, 1, 11'd304, 0, 0, 0);
        cycle(1, 0, 11'd304, 1, 0, 64);
        cycle(1, 0, 11'd304, 1, 0, 64);

        // One pixel per frame: crosses on tick 544, then frozen.
        for (int i = 0; i < 550; i++) begin
            cycle(1, 0, 11'd304, 1, 1, 64);
            repeat (3) cycle(1, 0, 11'd304, 1, 0, 64);
        end

        // Negative speed stalls; oversized speed clamps.
        cycle(1, 1, 11'd100, 0, 0, 0);
        cycle(1, 0, 11'd100, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 11'd100, 1, 1, -10);
            cycle(1, 0, 11'd100, 1, 0, -10);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 11'd100, 1, 1, 5000);
            cycle(1, 0, 11'd100, 1, 0, 5000);
        end

        // Fall to about Y=100, then drop visibility: back to idle, no exceed.
        for (int i = 0; i < 200 && (m_y >>> 6) < 100; i++) begin
            cycle(1, 0, 11'd100, 1, 1, 64);
        end
        repeat (3) cycle(1, 0, 11'd100, 0, 0, 64);
        cycle(1, 0, 11'd100, 1, 0, 640);
        repeat (3) cycle(1, 0, 11'd100, 1, 1, 640);
        // Reload and tick in the same cycle: reload only.
        cycle(1, 1, 11'd200, 1, 1, 2048);
        repeat (2) cycle(1, 0, 11'd200, 1, 0, 640);

        // Fall to about Y=200, then reset mid-flight.
        for (int i = 0; i < 100 && (m_y >>> 6) < 200; i++) begin
            cycle(1, 0, 11'd200, 1, 1, 640);
        end
        reset_now();
        cycle(0, 0, 11'd200, 1, 1, 640);
        repeat (4) cycle(1, 0, 11'd200, 1, 0, 640);
        repeat (3) cycle(1, 0, 11'd200, 1, 1, 64);

        // Zero speed: moves only under gravity.
        cycle(1, 1, 11'd50, 0, 0, 0);
        cycle(1, 0, 11'd50, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 11'd50, 1, 1, 0);
            cycle(1, 0, 11'd50, 1, 0, 0);
        end

        // Randomised traffic.
        for (int i = 0; i < 5000; i++) begin
            bit          ld;
            bit          sof;
            bit          vis;
            bit          rst_n;
            int          spd;
            logic [10:0] ix;
            ld    = (m_phase == 2) ? ($urandom_range(0, 9) == 0)
                                   : ($urandom_range(0, 199) == 0);
            sof   = ($urandom_range(0, 2) == 0);
            vis   = ($urandom_range(0, 49) != 0);
            rst_n = ($urandom_range(0, 999) != 0);
            spd   = int'($urandom_range(0, 3000)) - 300;
            ix    = 11'($urandom_range(0, 2047));
            cycle(rst_n, ld, ix, vis, sof, spd);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
